usr_serial_deserializer: RTL and testbench

- Receive-side counterpart of the 4-bit universal shift register's serial path.
- Accepts a qualified serial bit stream, either LSB-first or MSB-first, and assembles DATA_WIDTH-bit words.
- Presents each word on a valid/ready parallel interface through a one-entry holding buffer, so the next word can be collected while the current one waits.
- Sits between the serial link (sr/sl side of the shift register) and downstream parallel logic.

---
 rtl/usr_serial_deserializer_pkg.sv | 13 +
 rtl/usr_serial_deserializer_hold_buf.sv | 46 ++++
 rtl/usr_serial_deserializer.sv | 118 +++++++++++
 tb/tb_usr_serial_deserializer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_serial_deserializer_pkg.sv
// Shared state encoding and stream-direction constants for the serial deserializer.
package usr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } usr_state_e;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/usr_serial_deserializer_hold_buf.sv
// One-entry valid/ready holding register; a word completing while the entry is
// occupied and not being read is dropped and flagged in the sticky overrun bit.
module usr_hold_buf
    import usr_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  clr,
    input  logic                  sync_clr,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] word,
    input  logic                  perr,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] q_out,
    output logic                  out_valid,
    output logic                  out_perr,
    output logic                  overrun
);

    // A read and a new completion on the same edge reload the entry directly.
    always_ff @(posedge i_clk or negedge clr) begin
        if (!clr) begin
            q_out     <= '0;
            out_valid <= 1'b0;
            out_perr  <= 1'b0;
            overrun   <= 1'b0;
        end else if (sync_clr) begin
            q_out     <= '0;
            out_valid <= 1'b0;
            out_perr  <= 1'b0;
            overrun   <= 1'b0;
        end else if (load) begin
            if (!out_valid || out_ready) begin
                q_out     <= word;
                out_perr  <= perr;
                out_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/usr_serial_deserializer.sv
// Serial-to-parallel word assembler (LSB- or MSB-first) feeding a one-entry holding buffer.
// Define PARITY_CHECK_EN to consume a trailing even-parity bit per word and report out_perr.
module usr_serial_deserializer
    import usr_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  i_clk,
    input  logic                  clr,
    input  logic                  sync_clr,
    input  logic                  ser_in,
    input  logic                  ser_valid,
    input  logic                  dir,
    output logic [DATA_WIDTH-1:0] q_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_perr,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    usr_state_e            state;
    logic [DATA_WIDTH-1:0] sreg;
    logic [DATA_WIDTH-1:0] shifted;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  word_dir;
    logic                  shift_dir;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_word;
    logic                  load_perr;

    // The first bit of a word uses the live dir input; later bits use the latched one.
    always_comb begin
        shift_dir = (state == ST_IDLE) ? dir : word_dir;
        if (shift_dir == DIR_MSB_FIRST) begin
            shifted = {sreg[DATA_WIDTH-2:0], ser_in};
        end else begin
            shifted = {ser_in, sreg[DATA_WIDTH-1:1]};
        end
    end

`ifdef PARITY_CHECK_EN
    assign load      = (state == ST_PAR) && ser_valid;
    assign load_word = sreg;
    assign load_perr = (^sreg) ^ ser_in;
`else
    assign load      = (state == ST_SHIFT) && ser_valid && (cnt == LAST_CNT);
    assign load_word = shifted;
    assign load_perr = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge clr) begin
        if (!clr) begin
            state    <= ST_IDLE;
            sreg     <= '0;
            cnt      <= '0;
            word_dir <= DIR_LSB_FIRST;
        end else if (sync_clr) begin
            state    <= ST_IDLE;
            sreg     <= '0;
            cnt      <= '0;
            word_dir <= DIR_LSB_FIRST;
        end else if (ser_valid) begin
            case (state)
                ST_IDLE: begin
                    sreg     <= shifted;
                    word_dir <= dir;
                    cnt      <= CNT_WIDTH'(1);
                    state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    sreg <= shifted;
                    if (cnt == LAST_CNT) begin
`ifdef PARITY_CHECK_EN
                        cnt   <= cnt + 1'b1;
                        state <= ST_PAR;
`else
                        cnt   <= '0;
                        state <= ST_IDLE;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PAR: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    usr_hold_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_hold_buf (
        .i_clk    (i_clk),
        .clr      (clr),
        .sync_clr (sync_clr),
        .load     (load),
        .word     (load_word),
        .perr     (load_perr),
        .out_ready(out_ready),
        .q_out    (q_out),
        .out_valid(out_valid),
        .out_perr (out_perr),
        .overrun  (overrun)
    );

endmodule

// File: tb/tb_usr_serial_deserializer.sv
// Self-checking bench for usr_serial_deserializer (DATA_WIDTH=4): directed vectors,
// hand-written corner sequences and a randomized run against a word-level reference model.
module tb_usr_serial_deserializer;

    localparam int W = 4;

    logic         i_clk;
    logic         clr;
    logic         sync_clr;
    logic         ser_in;
    logic         ser_valid;
    logic         dir;
    logic [W-1:0] q_out;
    logic         out_valid;
    logic         out_ready;
    logic         out_perr;
    logic         busy;
    logic         overrun;

    int n_checks = 0;
    int n_fail   = 0;

    usr_serial_deserializer #(
        .DATA_WIDTH(W),
        .CNT_WIDTH (3)
    ) dut (
        .i_clk    (i_clk),
        .clr      (clr),
        .sync_clr (sync_clr),
        .ser_in   (ser_in),
        .ser_valid(ser_valid),
        .dir      (dir),
        .q_out    (q_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_perr (out_perr),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic         d;
        logic [W-1:0] seq;
        logic [W-1:0] exp_q;
    } vec_t;

    vec_t vecs[8];

    // Reference model state: the word being collected and the holding entry.
    int   m_cnt;
    int   m_word;
    logic m_wdir;
    logic m_par_phase;
    logic m_hv;
    int   m_hq;
    logic m_hp;
    logic m_ovr;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic d, input logic rdy);
        ser_valid = 1'b1;
        ser_in    = b;
        dir       = d;
        out_ready = rdy;
        tick();
        ser_valid = 1'b0;
    endtask

    // seq[i] is the i-th bit on the wire; rdy_last applies to the word's final bit.
    task automatic send_word(input logic [W-1:0] seq, input logic d, input logic rdy_mid,
                             input logic rdy_last);
        for (int i = 0; i < W; i++) begin
`ifdef PARITY_CHECK_EN
            send_bit(seq[i], d, rdy_mid);
`else
            send_bit(seq[i], d, (i == W - 1) ? rdy_last : rdy_mid);
`endif
        end
`ifdef PARITY_CHECK_EN
        send_bit(^seq, d, rdy_last);
`endif
    endtask

    task automatic model_reset();
        m_cnt       = 0;
        m_word      = 0;
        m_wdir      = 1'b0;
        m_par_phase = 1'b0;
        m_hv        = 1'b0;
        m_hq        = 0;
        m_hp        = 1'b0;
        m_ovr       = 1'b0;
    endtask

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic done;
        int   cw;
        logic cp;
        int   pos;
        done = 1'b0;
        cw   = 0;
        cp   = 1'b0;
        if (sync_clr) begin
            model_reset();
        end else begin
            if (ser_valid) begin
                if (m_par_phase) begin
                    done        = 1'b1;
                    cw          = m_word;
                    cp          = (^m_word[W-1:0]) ^ ser_in;
                    m_par_phase = 1'b0;
                    m_word      = 0;
                end else begin
                    if (m_cnt == 0) m_wdir = dir;
                    pos    = m_wdir ? (W - 1 - m_cnt) : m_cnt;
                    m_word = m_word + (ser_in ? (1 << pos) : 0);
                    m_cnt++;
                    if (m_cnt == W) begin
                        m_cnt = 0;
`ifdef PARITY_CHECK_EN
                        m_par_phase = 1'b1;
`else
                        done   = 1'b1;
                        cw     = m_word;
                        m_word = 0;
`endif
                    end
                end
            end
            if (done) begin
                if (!m_hv || out_ready) begin
                    m_hv = 1'b1;
                    m_hq = cw;
                    m_hp = cp;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_hv && out_ready) begin
                m_hv = 1'b0;
            end
        end
    endtask

    initial begin
        clr       = 1'b0;
        sync_clr  = 1'b0;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        dir       = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{1'b0, 4'b1101, 4'b1101};
        vecs[1] = '{1'b1, 4'b1001, 4'b1001};
        vecs[2] = '{1'b1, 4'b0001, 4'b1000};
        vecs[3] = '{1'b0, 4'b0001, 4'b0001};
        vecs[4] = '{1'b1, 4'b0011, 4'b1100};
        vecs[5] = '{1'b1, 4'b1110, 4'b0111};
        vecs[6] = '{1'b0, 4'b0000, 4'b0000};
        vecs[7] = '{1'b0, 4'b1111, 4'b1111};

        // Reset state
        #12;
        check_output("reset_q", 32'(q_out), 0);
        check_output("reset_valid", 32'(out_valid), 0);
        check_output("reset_busy", 32'(busy), 0);
        check_output("reset_overrun", 32'(overrun), 0);
        check_output("reset_perr", 32'(out_perr), 0);
        clr = 1'b1;
        tick();

        // LSB-first: valid for exactly one cycle
        send_word(4'b1101, 1'b0, 1'b1, 1'b1);
        check_output("lsb_q", 32'(q_out), 32'hD);
        check_output("lsb_valid", 32'(out_valid), 1);
        check_output("lsb_busy_after", 32'(busy), 0);
        tick();
        check_output("lsb_valid_fall", 32'(out_valid), 0);

        // Directed table
        for (int v = 0; v < 8; v++) begin
            send_word(vecs[v].seq, vecs[v].d, 1'b1, 1'b1);
            check_output($sformatf("vec%0d_q", v), 32'(q_out), 32'(vecs[v].exp_q));
            check_output($sformatf("vec%0d_valid", v), 32'(out_valid), 1);
            check_output($sformatf("vec%0d_perr", v), 32'(out_perr), 0);
            tick();
            check_output($sformatf("vec%0d_drain", v), 32'(out_valid), 0);
        end

        // MSB-first with gaps and dir toggling mid-word
        begin
            logic [W-1:0] bits;
            bits = 4'b1001;
            for (int i = 0; i < W; i++) begin
                send_bit(bits[i], (i % 2 == 0), 1'b1);
                if (i < W - 1) begin
                    check_output($sformatf("gap_busy_bit%0d", i), 32'(busy), 1);
                    tick();
                    check_output($sformatf("gap_busy_idle%0d", i), 32'(busy), 1);
                end
            end
`ifdef PARITY_CHECK_EN
            send_bit(1'b0, 1'b0, 1'b1);
`endif
            check_output("gap_q", 32'(q_out), 32'h9);
            check_output("gap_valid", 32'(out_valid), 1);
            check_output("gap_busy_done", 32'(busy), 0);
            tick();
        end

        // Backpressure and overrun
        send_word(4'hA, 1'b0, 1'b0, 1'b0);
        check_output("bp_first_q", 32'(q_out), 32'hA);
        check_output("bp_first_ovr", 32'(overrun), 0);
        send_word(4'h5, 1'b0, 1'b0, 1'b0);
        check_output("bp_hold_q", 32'(q_out), 32'hA);
        check_output("bp_hold_valid", 32'(out_valid), 1);
        check_output("bp_overrun", 32'(overrun), 1);
        out_ready = 1'b1;
        tick();
        check_output("bp_accept_valid", 32'(out_valid), 0);
        check_output("bp_overrun_sticky", 32'(overrun), 1);
        tick();
        check_output("bp_overrun_sticky2", 32'(overrun), 1);
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        check_output("bp_sync_clr_ovr", 32'(overrun), 0);
        check_output("bp_sync_clr_q", 32'(q_out), 0);

        // Simultaneous read and reload
        send_word(4'h3, 1'b0, 1'b0, 1'b0);
        check_output("sim_first_q", 32'(q_out), 32'h3);
        send_word(4'hC, 1'b0, 1'b0, 1'b1);
        check_output("sim_q", 32'(q_out), 32'hC);
        check_output("sim_valid", 32'(out_valid), 1);
        check_output("sim_overrun", 32'(overrun), 0);
        out_ready = 1'b1;
        tick();
        check_output("sim_drain", 32'(out_valid), 0);

        // Asynchronous reset mid-word
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        check_output("arst_busy_before", 32'(busy), 1);
        #2 clr = 1'b0;
        #1;
        check_output("arst_q", 32'(q_out), 0);
        check_output("arst_busy", 32'(busy), 0);
        check_output("arst_valid", 32'(out_valid), 0);
        #2 clr = 1'b1;
        tick();
        send_word(4'b0110, 1'b0, 1'b1, 1'b1);
        check_output("arst_next_q", 32'(q_out), 32'h6);
        check_output("arst_next_valid", 32'(out_valid), 1);
        tick();

`ifdef PARITY_CHECK_EN
        // Parity good and bad on data 1,1,0,0
        begin
            logic [W-1:0] pb;
            pb = 4'b0011;
            for (int i = 0; i < W; i++) send_bit(pb[i], 1'b0, 1'b1);
            send_bit(1'b0, 1'b0, 1'b1);
            check_output("par_ok_q", 32'(q_out), 32'h3);
            check_output("par_ok_perr", 32'(out_perr), 0);
            for (int i = 0; i < W; i++) send_bit(pb[i], 1'b0, 1'b1);
            send_bit(1'b1, 1'b0, 1'b1);
            check_output("par_bad_q", 32'(q_out), 32'h3);
            check_output("par_bad_perr", 32'(out_perr), 1);
            tick();
        end
`endif

        // Randomized run against the reference model
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        model_reset();
        for (int c = 0; c < 500; c++) begin
            ser_valid = ($urandom_range(0, 3) != 0);
            ser_in    = 1'($urandom);
            dir       = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            sync_clr  = ($urandom_range(0, 60) == 0);
            model_step();
            tick();
            check_output($sformatf("rnd%0d_valid", c), 32'(out_valid), 32'(m_hv));
            check_output($sformatf("rnd%0d_q", c), 32'(q_out), 32'(m_hq));
            check_output($sformatf("rnd%0d_perr", c), 32'(out_perr), 32'(m_hp));
            check_output($sformatf("rnd%0d_busy", c), 32'(busy), 32'((m_cnt != 0) || m_par_phase));
            check_output($sformatf("rnd%0d_ovr", c), 32'(overrun), 32'(m_ovr));
        end
        sync_clr  = 1'b0;
        ser_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
